// File: rtl/alu_reservation_station.sv
// +------------------------------------------------------------------------+
// | alu_reservation_station                                                |
// | Age-ordered compacting reservation station feeding the ALU pipe.       |
// | Optional feature macro: ALU_RS_WAKEUP_BYPASS_EN (same-cycle wakeup).   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

package alu_rs_pkg;
  typedef struct packed {
    logic       valid;
    logic [6:0] ps1;
    logic [6:0] ps2;
    logic       ps1_ready;
    logic       ps2_ready;
  } rs_data_t;
endpackage

module alu_reservation_station
  import alu_rs_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int NUM_WB = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dispatch_valid,
  input  rs_data_t                     dispatch_data,
  output logic                         dispatch_ready,
  input  logic [NUM_WB-1:0]            wb_valid,
  input  logic [NUM_WB-1:0][6:0]       wb_pd,
  input  logic                         fu_ready,
  input  logic                         flush,
  output logic                         alu_issued,
  output rs_data_t                     alu_rs_data,
  output logic [$clog2(DEPTH):0]       occupancy
);

  localparam int IW = $clog2(DEPTH);
  localparam int OW = IW + 1;

  rs_data_t          entries_q [DEPTH];
  rs_data_t          entries_d [DEPTH];
  logic [OW-1:0]     occ_q;
  logic [OW-1:0]     occ_d;

  logic [DEPTH-1:0]  hit1;
  logic [DEPTH-1:0]  hit2;
  logic              disp_hit1;
  logic              disp_hit2;
  logic [DEPTH-1:0]  sel_rdy1;
  logic [DEPTH-1:0]  sel_rdy2;
  logic [DEPTH-1:0]  elig;
  logic              sel_found;
  logic [IW-1:0]     sel_idx;
  logic              issue;
  logic              disp_fire;
  logic [OW-1:0]     wr_idx;
  rs_data_t          disp_entry;
  rs_data_t          woke [DEPTH+1];
  logic              unused_dispatch_valid_field;

  // Dispatch handshake is carried by dispatch_valid alone.
  assign unused_dispatch_valid_field = dispatch_data.valid;

  // Tag matches of every writeback port against every stored and incoming source.
  always_comb begin
    hit1      = '0;
    hit2      = '0;
    disp_hit1 = 1'b0;
    disp_hit2 = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      for (int i = 0; i < NUM_WB; i++) begin
        if (wb_valid[i] && (wb_pd[i] == entries_q[k].ps1)) hit1[k] = 1'b1;
        if (wb_valid[i] && (wb_pd[i] == entries_q[k].ps2)) hit2[k] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb_valid[i] && (wb_pd[i] == dispatch_data.ps1)) disp_hit1 = 1'b1;
      if (wb_valid[i] && (wb_pd[i] == dispatch_data.ps2)) disp_hit2 = 1'b1;
    end
  end

  always_comb begin
    sel_rdy1  = '0;
    sel_rdy2  = '0;
    elig      = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
`ifdef ALU_RS_WAKEUP_BYPASS_EN
      sel_rdy1[k] = entries_q[k].ps1_ready | hit1[k];
      sel_rdy2[k] = entries_q[k].ps2_ready | hit2[k];
`else
      sel_rdy1[k] = entries_q[k].ps1_ready;
      sel_rdy2[k] = entries_q[k].ps2_ready;
`endif
      elig[k] = entries_q[k].valid & sel_rdy1[k] & sel_rdy2[k];
    end
    // Descending scan so the lowest (oldest) eligible index wins.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (elig[k]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(k);
      end
    end
  end

  assign issue          = fu_ready & sel_found;
  assign alu_issued     = issue;
  assign dispatch_ready = (occ_q < OW'(DEPTH));
  assign disp_fire      = dispatch_valid & dispatch_ready;
  assign occupancy      = occ_q;

  always_comb begin
    alu_rs_data = '0;
    if (issue) begin
      alu_rs_data           = entries_q[sel_idx];
      alu_rs_data.ps1_ready = sel_rdy1[sel_idx];
      alu_rs_data.ps2_ready = sel_rdy2[sel_idx];
    end
  end

  always_comb begin
    disp_entry           = '0;
    disp_entry.valid     = 1'b1;
    disp_entry.ps1       = dispatch_data.ps1;
    disp_entry.ps2       = dispatch_data.ps2;
    disp_entry.ps1_ready = dispatch_data.ps1_ready | disp_hit1 | (dispatch_data.ps1 == 7'd0);
    disp_entry.ps2_ready = dispatch_data.ps2_ready | disp_hit2 | (dispatch_data.ps2 == 7'd0);
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      woke[k] = entries_q[k];
      if (entries_q[k].valid) begin
        woke[k].ps1_ready = entries_q[k].ps1_ready | hit1[k];
        woke[k].ps2_ready = entries_q[k].ps2_ready | hit2[k];
      end
    end
    woke[DEPTH] = '0;

    // Entries above the issued slot slide down; the zero sentinel fills the top.
    for (int k = 0; k < DEPTH; k++) begin
      if (issue && (k >= int'(sel_idx))) entries_d[k] = woke[k+1];
      else                               entries_d[k] = woke[k];
    end

    wr_idx = occ_q - OW'(issue);
    if (disp_fire) entries_d[wr_idx[IW-1:0]] = disp_entry;
    occ_d = occ_q + OW'(disp_fire) - OW'(issue);

    if (flush) begin
      for (int k = 0; k < DEPTH; k++) entries_d[k] = '0;
      occ_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) entries_q[k] <= '0;
      occ_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) entries_q[k] <= entries_d[k];
      occ_q <= occ_d;
    end
  end

endmodule

`default_nettype wire
